// File: rtl/mhp_frame_tx_pkg.sv
// Shared constants and state type for the MHP frame serializer and its RX counterpart.
package mhp_frame_tx_pkg;
  localparam int MHP_HDR_BYTES  = 7;
  localparam int MHP_CSUM_BYTES = 2;

  // Byte offsets of the header fields inside the 7-byte header
  localparam int OFF_DST     = 0;
  localparam int OFF_SRC     = 2;
  localparam int OFF_SIZE    = 4;
  localparam int OFF_DIRTYPE = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_t;
endpackage

// File: rtl/mhp_frame_tx_if.sv
// Valid/ready byte stream between the frame serializer and the TX FIFO/UART.
interface mhp_frame_tx_if;
  logic [7:0] o_wdata;
  logic       o_wvalid;
  logic       o_wlast;
  logic       i_wready;

  modport master (output o_wdata, output o_wvalid, output o_wlast, input i_wready);
  modport slave  (input o_wdata, input o_wvalid, input o_wlast, output i_wready);
endinterface

// File: rtl/mhp_csum16.sv
// 16-bit additive byte checksum, shared with the RX frame checker.
module mhp_csum16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_add_en,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_sum
);
  logic [15:0] r_sum;

  // Running sum; clear has priority over accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_sum <= '0;
    else if (i_clear)  r_sum <= '0;
    else if (i_add_en) r_sum <= r_sum + {8'h00, i_byte};
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/mhp_frame_tx.sv
// MHP frame serializer: header, clipped payload and optional checksum over a byte stream.
// state | meaning
// IDLE  | waiting for start
// HDR   | sending the 7 header bytes (first cycle loads byte 0)
// PAY   | sending L = min(i_size, PAYLOAD_BYTES) payload bytes
// CSUM  | sending checksum high then low byte
// DONE  | one-cycle done pulse, start ignored
module mhp_frame_tx
  import mhp_frame_tx_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 42,
  parameter bit CSUM_EN       = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic [15:0]                i_dst,
  input  logic [15:0]                i_src,
  input  logic [15:0]                i_size,
  input  logic                       i_dir,
  input  logic [6:0]                 i_type,
  input  logic [PAYLOAD_BYTES*8-1:0] i_payload,
  mhp_frame_tx_if.master             wr,
  output logic                       o_clip
);
  localparam int CW = ($clog2(PAYLOAD_BYTES + 1) > 3) ? $clog2(PAYLOAD_BYTES + 1) : 3;
  localparam int PW = $clog2(PAYLOAD_BYTES * 8);

  state_t                     r_state, w_state_nxt;
  logic [CW-1:0]              r_cnt, w_cnt_nxt, w_cnt_inc, r_len, w_len_in;
  logic [MHP_HDR_BYTES*8-1:0] r_hdr;
  logic [PAYLOAD_BYTES*8-1:0] r_payload;
  logic                       r_clip, r_valid, r_last, w_valid_nxt, w_last_nxt;
  logic [7:0]                 r_data, w_data_nxt, w_hdr_byte, w_pay_byte;
  logic                       w_accept, w_start_acc, w_csum_add;
  logic [15:0]                w_sum, w_sum_fin;
  logic [2:0]                 w_hidx;
  logic [CW-1:0]              w_pidx;
  logic [5:0]                 w_hbit;
  logic [PW-1:0]              w_pbit;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_accept    = r_valid && wr.i_wready;
  assign w_csum_add  = w_accept && ((r_state == ST_HDR) || (r_state == ST_PAY));
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_len_in    = (i_size > 16'(PAYLOAD_BYTES)) ? CW'(PAYLOAD_BYTES) : CW'(i_size);

  // Byte to load next: the following header/payload byte, or byte 0 when entering a field
  assign w_hidx     = r_valid ? w_cnt_inc[2:0] : 3'd0;
  assign w_hbit     = {w_hidx, 3'b000};
  assign w_hdr_byte = r_hdr[w_hbit +: 8];
  assign w_pidx     = (r_state == ST_PAY) ? w_cnt_inc : '0;
  assign w_pbit     = PW'(w_pidx) << 3;
  assign w_pay_byte = r_payload[w_pbit +: 8];

  // Checksum high byte must include the payload byte being accepted on the same edge
  assign w_sum_fin = w_sum + {8'h00, r_data};

  mhp_csum16 u_csum (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start_acc),
    .i_add_en (w_csum_add),
    .i_byte   (r_data),
    .o_sum    (w_sum)
  );

  // Next-state and next output byte; output register only moves on load or accepted beat
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_HDR;
          w_cnt_nxt   = '0;
        end
      end
      ST_HDR: begin
        if (!r_valid) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_hdr_byte;
          w_last_nxt  = 1'b0;
        end else if (w_accept) begin
          if (r_cnt == CW'(MHP_HDR_BYTES - 1)) begin
            w_cnt_nxt = '0;
            if (r_len != '0) begin
              w_state_nxt = ST_PAY;
              w_data_nxt  = w_pay_byte;
              w_last_nxt  = !CSUM_EN && (r_len == CW'(1));
            end else if (CSUM_EN) begin
              w_state_nxt = ST_CSUM;
              w_data_nxt  = w_sum_fin[15:8];
              w_last_nxt  = 1'b0;
            end else begin
              w_state_nxt = ST_DONE;
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
            end
          end else begin
            w_cnt_nxt  = w_cnt_inc;
            w_data_nxt = w_hdr_byte;
            w_last_nxt = !CSUM_EN && (r_len == '0) && (w_cnt_inc == CW'(MHP_HDR_BYTES - 1));
          end
        end
      end
      ST_PAY: begin
        if (w_accept) begin
          if (w_cnt_inc == r_len) begin
            w_cnt_nxt = '0;
            if (CSUM_EN) begin
              w_state_nxt = ST_CSUM;
              w_data_nxt  = w_sum_fin[15:8];
              w_last_nxt  = 1'b0;
            end else begin
              w_state_nxt = ST_DONE;
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
            end
          end else begin
            w_cnt_nxt  = w_cnt_inc;
            w_data_nxt = w_pay_byte;
            w_last_nxt = !CSUM_EN && ((w_cnt_inc + CW'(1)) == r_len);
          end
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          if (r_cnt != CW'(MHP_CSUM_BYTES - 1)) begin
            w_cnt_nxt  = w_cnt_inc;
            w_data_nxt = w_sum[7:0];
            w_last_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, byte counter and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Capture header, payload, clipped length and clip flag at start acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr     <= '0;
      r_payload <= '0;
      r_len     <= '0;
      r_clip    <= 1'b0;
    end else if (w_start_acc) begin
      r_hdr[8*OFF_DST +: 16]    <= i_dst;
      r_hdr[8*OFF_SRC +: 16]    <= i_src;
      r_hdr[8*OFF_SIZE +: 16]   <= i_size;
      r_hdr[8*OFF_DIRTYPE +: 8] <= {i_dir, i_type};
      r_payload                 <= i_payload;
      r_len                     <= w_len_in;
      r_clip                    <= (i_size > 16'(PAYLOAD_BYTES));
    end
  end

  assign busy        = (r_state == ST_HDR) || (r_state == ST_PAY) || (r_state == ST_CSUM);
  assign done        = (r_state == ST_DONE);
  assign wr.o_wdata  = r_data;
  assign wr.o_wvalid = r_valid;
  assign wr.o_wlast  = r_last;
  assign o_clip      = r_clip;
endmodule

// File: tb/tb_mhp_frame_tx.sv
// Scoreboard bench for mhp_frame_tx: checksum and no-checksum instances, shared stimulus.
module tb_mhp_frame_tx;
  localparam int PB = 42;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            sel = 1'b0;
  logic            rdy = 1'b1;
  logic [15:0]     f_dst = '0, f_src = '0, f_size = '0;
  logic            f_dir = 1'b0;
  logic [6:0]      f_type = '0;
  logic [PB*8-1:0] f_payload = '0;
  logic            start_a, start_b;
  logic            busy_a, done_a, clip_a, busy_b, done_b, clip_b;
  logic            m_valid, m_last, m_busy, m_done, m_clip;
  logic [7:0]      m_data;

  int    n_checks = 0;
  int    n_errors = 0;
  int    rmode = 0;
  int    rphase = 0;
  beat_t exp_q[$];
  logic  mon_stall = 1'b0, mon_sl = 1'b0, mon_was_last = 1'b0;
  logic [7:0] mon_sd = '0;

  mhp_frame_tx_if bus_a();
  mhp_frame_tx_if bus_b();

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign bus_a.i_wready = rdy;
  assign bus_b.i_wready = rdy;

  mhp_frame_tx #(.PAYLOAD_BYTES(PB), .CSUM_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .i_dst(f_dst), .i_src(f_src), .i_size(f_size), .i_dir(f_dir), .i_type(f_type),
    .i_payload(f_payload), .wr(bus_a), .o_clip(clip_a)
  );

  mhp_frame_tx #(.PAYLOAD_BYTES(PB), .CSUM_EN(1'b0)) u_dut_nocsum (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .i_dst(f_dst), .i_src(f_src), .i_size(f_size), .i_dir(f_dir), .i_type(f_type),
    .i_payload(f_payload), .wr(bus_b), .o_clip(clip_b)
  );

  assign m_valid = sel ? bus_b.o_wvalid : bus_a.o_wvalid;
  assign m_data  = sel ? bus_b.o_wdata  : bus_a.o_wdata;
  assign m_last  = sel ? bus_b.o_wlast  : bus_a.o_wlast;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_clip  = sel ? clip_b : clip_a;

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference frame built straight from the field rules
  task automatic push_frame(input bit csum_en);
    logic [7:0]  b[$];
    logic [31:0] sum;
    int          len;
    beat_t       e;
    sum = 0;
    len = (f_size > PB) ? PB : int'(f_size);
    b.push_back(f_dst[7:0]);  b.push_back(f_dst[15:8]);
    b.push_back(f_src[7:0]);  b.push_back(f_src[15:8]);
    b.push_back(f_size[7:0]); b.push_back(f_size[15:8]);
    b.push_back({f_dir, f_type});
    for (int k = 0; k < len; k++) b.push_back(f_payload[8*k +: 8]);
    foreach (b[i]) sum += 32'(b[i]);
    if (csum_en) begin
      b.push_back(sum[15:8]);
      b.push_back(sum[7:0]);
    end
    foreach (b[i]) begin
      e.data = b[i];
      e.last = (i == b.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_fields();
    f_dst  = 16'($urandom);
    f_src  = 16'($urandom);
    f_size = 16'($urandom_range(0, 60));
    f_dir  = 1'($urandom);
    f_type = 7'($urandom);
    for (int k = 0; k < PB; k++) f_payload[8*k +: 8] = 8'($urandom);
  endtask

  task automatic do_start();
    @(negedge clk); #3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_at_accept", 32'(m_busy), 1);
    check("valid_latency_n", 32'(m_valid), 0);
    @(posedge clk); #1;
    check("valid_latency_n1", 32'(m_valid), 1);
    check("first_byte", 32'(m_data), 32'(f_dst[7:0]));
  endtask

  task automatic wait_done(input logic exp_clip);
    int cyc;
    cyc = 0;
    while (!m_done && cyc < 600) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("done_seen", 32'(m_done), 1);
    check("frame_beats_left", 32'(exp_q.size()), 0);
    check("clip", 32'(m_clip), 32'(exp_clip));
    exp_q.delete();
  endtask

  task automatic run_frame();
    logic exp_clip;
    exp_clip = (f_size > PB);
    push_frame(!sel);
    do_start();
    wait_done(exp_clip);
  endtask

  // Sink ready pattern: always ready, 1,0,0,1 cycle, or random
  initial begin
    forever begin
      @(negedge clk);
      case (rmode)
        0: rdy = 1'b1;
        1: begin
          rdy    = (rphase == 0) || (rphase == 3);
          rphase = (rphase + 1) % 4;
        end
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transferring beat, checks stall hold and done timing
  initial begin
    beat_t e;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        mon_stall    = 1'b0;
        mon_was_last = 1'b0;
        continue;
      end
      if (mon_was_last || m_done) check("done_pulse", 32'(m_done), 32'(mon_was_last));
      mon_was_last = 1'b0;
      if (mon_stall) check("stall_hold", {29'd0, m_valid, m_last, 1'b0} | 32'(m_data) << 3,
                           {29'd0, 1'b1, mon_sl, 1'b0} | 32'(mon_sd) << 3);
      mon_stall = 1'b0;
      if (m_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got 0x%0h with nothing expected at %0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", {23'd0, m_data, m_last}, {23'd0, e.data, e.last});
          mon_was_last = e.last;
        end
      end else if (m_valid) begin
        mon_stall = 1'b1;
        mon_sd    = m_data;
        mon_sl    = m_last;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus_a.o_wvalid), 0);
    check("rst_data", 32'(bus_a.o_wdata), 0);
    check("rst_last", 32'(bus_a.o_wlast), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_clip", 32'(clip_a), 0);
    check("rst_valid_nocsum", 32'(bus_b.o_wvalid), 0);
    rst = 1'b0;

    // Reference frame, sink always ready
    f_dst = 16'h1234; f_src = 16'hABCD; f_size = 16'd42; f_dir = 1'b1; f_type = 7'h05;
    for (int k = 0; k < PB; k++) f_payload[8*k +: 8] = 8'(k);
    rmode = 0;
    run_frame();

    // Same frame with ready toggling 1,0,0,1
    rmode = 1; rphase = 0;
    run_frame();

    // Empty payload
    rmode = 0;
    f_size = 16'd0;
    run_frame();

    // Oversize request is clipped, clip stays until next start
    f_size = 16'd100;
    run_frame();
    repeat (3) @(negedge clk);
    check("clip_sticky", 32'(m_clip), 1);
    f_size = 16'd10;
    run_frame();

    // Start pulses during byte 20 and during DONE are ignored
    f_size = 16'd42;
    push_frame(1'b1);
    do_start();
    repeat (19) @(negedge clk);
    #3 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_in_done_ignored", 32'(m_busy), 0);
    f_dst = 16'h0F0F; f_size = 16'd5;
    run_frame();

    // Asynchronous reset mid-payload
    f_size = 16'd42;
    push_frame(1'b1);
    do_start();
    repeat (15) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 32'(m_valid), 0);
    check("arst_busy", 32'(m_busy), 0);
    check("arst_done", 32'(m_done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame();

    // Random frames with random backpressure
    rmode = 2;
    for (int n = 0; n < 8; n++) begin
      rand_fields();
      run_frame();
    end

    // No-checksum instance: 7 + L beats, last on final payload/header byte
    sel = 1'b1;
    rmode = 0;
    f_size = 16'd5;  run_frame();
    f_size = 16'd0;  run_frame();
    f_size = 16'd42; run_frame();
    rmode = 2;
    for (int n = 0; n < 4; n++) begin
      rand_fields();
      run_frame();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
